// File: rtl/ibex_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// ibex_mem_arb_pkg
// Shared types for the Ibex instruction/data memory arbiter.
//   src_e       : identifies which requester issued a transaction
//   arb_state_e : arbiter address-phase state
// ---------------------------------------------------------------------------
package ibex_mem_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam logic [3:0] BE_ALL = 4'hF;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    endfunction

endpackage

// File: rtl/ibex_mem_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// ibex_mem_arb_id_fifo
// In-order FIFO of source IDs, one entry per granted-but-unanswered
// transaction. A push and a pop in the same cycle are accepted even when the
// FIFO is full, because the pop frees the slot the push needs.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   i_push, i_push_src   enqueue a source ID
//   i_pop                dequeue the head (ignored when empty)
//   o_head               source ID at the head
//   o_full, o_empty      occupancy flags
//   o_count              current occupancy
// ---------------------------------------------------------------------------
module ibex_mem_arb_id_fifo
    import ibex_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       i_push,
    input  src_e                       i_push_src,
    input  logic                       i_pop,
    output src_e                       o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    src_e          r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= SRC_INSTR;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_push_src;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ibex_mem_arbiter
// Shares one downstream req/gnt/rvalid memory port between the Ibex
// instruction and data interfaces. Address phase and grant are combinational
// pass-through; responses are routed in order using a FIFO of source IDs.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ARB_IDLE   | free to pick a winner among current requests
// ARB_LOCKED | a request was presented but not granted; keep presenting
//            | the owner's request until mem_gnt_i
//
// Optional build macro:
//   IBEX_MEM_ARB_ROUND_ROBIN_EN  simultaneous requests alternate; pointer
//                                moves to the loser after each grant.
//                                Undefined: fixed priority (DATA_PRIORITY).
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   instr_* / data_*                  Ibex-side handshakes
//   mem_*                             downstream handshake
//   outstanding_o                     ID FIFO occupancy
//   protocol_err_o                    sticky: rvalid with nothing outstanding
// ---------------------------------------------------------------------------
module ibex_mem_arbiter
    import ibex_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          DATA_PRIORITY   = 1'b1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,

    input  logic                               instr_req_i,
    output logic                               instr_gnt_o,
    output logic                               instr_rvalid_o,
    output logic                               instr_err_o,
    input  logic [31:0]                        instr_addr_i,
    output logic [31:0]                        instr_rdata_o,

    input  logic                               data_req_i,
    output logic                               data_gnt_o,
    output logic                               data_rvalid_o,
    output logic                               data_err_o,
    input  logic                               data_we_i,
    input  logic [3:0]                         data_be_i,
    input  logic [31:0]                        data_addr_i,
    input  logic [31:0]                        data_wdata_i,
    output logic [31:0]                        data_rdata_o,

    output logic                               mem_req_o,
    input  logic                               mem_gnt_i,
    input  logic                               mem_rvalid_i,
    input  logic                               mem_err_i,
    output logic                               mem_we_o,
    output logic [3:0]                         mem_be_o,
    output logic [31:0]                        mem_addr_o,
    output logic [31:0]                        mem_wdata_o,
    input  logic [31:0]                        mem_rdata_i,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               protocol_err_o
);

    arb_state_e r_state;
    src_e       r_owner;
    logic       r_protocol_err;

    logic       w_full;
    logic       w_empty;
    src_e       w_head;
    logic       w_pop;
    logic       w_push;
    logic       w_can_issue;
    logic       w_both;
    src_e       w_winner;
    logic       w_sel_valid;
    src_e       w_sel_src;

    assign w_pop       = mem_rvalid_i && !w_empty;
    // A response in this cycle frees a slot, so a full FIFO may still issue.
    assign w_can_issue = !w_full || w_pop;
    assign w_both      = instr_req_i && data_req_i;

`ifdef IBEX_MEM_ARB_ROUND_ROBIN_EN
    src_e r_rr_ptr;

    assign w_winner = w_both ? r_rr_ptr : (instr_req_i ? SRC_INSTR : SRC_DATA);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= SRC_INSTR;
        end else if (w_push) begin
            r_rr_ptr <= other_src(w_sel_src);
        end
    end
`else
    assign w_winner = w_both ? (DATA_PRIORITY ? SRC_DATA : SRC_INSTR)
                             : (instr_req_i ? SRC_INSTR : SRC_DATA);
`endif

    // LOCKED never re-arbitrates: the downstream address must not change
    // while a request is waiting for its grant.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_src   = w_winner;
        if (r_state == ARB_LOCKED) begin
            w_sel_valid = 1'b1;
            w_sel_src   = r_owner;
        end else if ((instr_req_i || data_req_i) && w_can_issue) begin
            w_sel_valid = 1'b1;
        end
    end

    always_comb begin
        mem_req_o   = w_sel_valid;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (w_sel_valid) begin
            if (w_sel_src == SRC_INSTR) begin
                mem_be_o   = BE_ALL;
                mem_addr_o = instr_addr_i;
            end else begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end
        end
    end

    assign w_push      = w_sel_valid && mem_gnt_i;
    assign instr_gnt_o = w_push && (w_sel_src == SRC_INSTR);
    assign data_gnt_o  = w_push && (w_sel_src == SRC_DATA);

    assign instr_rvalid_o = w_pop && (w_head == SRC_INSTR);
    assign data_rvalid_o  = w_pop && (w_head == SRC_DATA);
    assign instr_err_o    = instr_rvalid_o && mem_err_i;
    assign data_err_o     = data_rvalid_o && mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign protocol_err_o = r_protocol_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ARB_IDLE;
            r_owner        <= SRC_INSTR;
            r_protocol_err <= 1'b0;
        end else begin
            if (mem_rvalid_i && w_empty) begin
                r_protocol_err <= 1'b1;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_sel_valid && !mem_gnt_i) begin
                        r_state <= ARB_LOCKED;
                        r_owner <= w_sel_src;
                    end
                end
                ARB_LOCKED: begin
                    if (mem_gnt_i) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    ibex_mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push     (w_push),
        .i_push_src (w_sel_src),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (outstanding_o)
    );

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
module tb_ibex_mem_arbiter;

    localparam int MAXO  = 2;
    localparam bit DPRIO = 1'b1;
`ifdef IBEX_MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    // After reset, who wins a simultaneous request.
    localparam int FIRST = RR ? 0 : (DPRIO ? 1 : 0);

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_err_o, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_err_i, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [$clog2(MAXO):0] outstanding_o;
    logic        protocol_err_o;

    always #5 clk_i = ~clk_i;

    ibex_mem_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .DATA_PRIORITY   (DPRIO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_err_o    (instr_err_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_err_o     (data_err_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_err_i      (mem_err_i),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of issuers of outstanding transactions,
    // the requester currently holding the port (-1 = none), sticky error,
    // and whose turn it is under alternation.
    int m_q[$];
    int m_locked = -1;
    bit m_perr   = 1'b0;
    int m_rr     = 0;

    bit n_pop;
    int n_push_src;
    int n_lock;
    bit n_perr_set;
    bit exp_igrant, exp_dgrant;
    int obs_grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0; instr_addr_i = 32'h0;
        data_req_i   = 1'b0; data_we_i    = 1'b0; data_be_i = 4'h0;
        data_addr_i  = 32'h0; data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        mem_rdata_i  = 32'h0;
    endtask

    // Compare all outputs against the model for the current inputs and
    // compute the model's next state (applied by tick()).
    task automatic check_cycle(input string tag);
        int          sel;
        int          head;
        bit          pop;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we;
        #1;
        sel = -1;
        if (m_locked >= 0) begin
            sel = m_locked;
        end else if (instr_req_i || data_req_i) begin
            if (m_q.size() < MAXO || (mem_rvalid_i && m_q.size() > 0)) begin
                if (instr_req_i && data_req_i) sel = RR ? m_rr : (DPRIO ? 1 : 0);
                else                           sel = instr_req_i ? 0 : 1;
            end
        end
        e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0; e_we = 1'b0;
        if (sel == 0) begin
            e_addr = instr_addr_i; e_be = 4'hF;
        end else if (sel == 1) begin
            e_addr = data_addr_i; e_wdata = data_wdata_i; e_be = data_be_i; e_we = data_we_i;
        end
        pop  = mem_rvalid_i && (m_q.size() > 0);
        head = pop ? m_q[0] : -1;
        exp_igrant = (sel == 0) && mem_gnt_i;
        exp_dgrant = (sel == 1) && mem_gnt_i;

        chk({tag, ".mem_req"},    mem_req_o,      sel >= 0);
        chk({tag, ".mem_addr"},   mem_addr_o,     e_addr);
        chk({tag, ".mem_wdata"},  mem_wdata_o,    e_wdata);
        chk({tag, ".mem_be"},     mem_be_o,       e_be);
        chk({tag, ".mem_we"},     mem_we_o,       e_we);
        chk({tag, ".i_gnt"},      instr_gnt_o,    exp_igrant);
        chk({tag, ".d_gnt"},      data_gnt_o,     exp_dgrant);
        chk({tag, ".i_rvalid"},   instr_rvalid_o, head == 0);
        chk({tag, ".d_rvalid"},   data_rvalid_o,  head == 1);
        chk({tag, ".i_err"},      instr_err_o,    (head == 0) && mem_err_i);
        chk({tag, ".d_err"},      data_err_o,     (head == 1) && mem_err_i);
        chk({tag, ".i_rdata"},    instr_rdata_o,  mem_rdata_i);
        chk({tag, ".d_rdata"},    data_rdata_o,   mem_rdata_i);
        chk({tag, ".outstand"},   outstanding_o,  m_q.size());
        chk({tag, ".proto_err"},  protocol_err_o, m_perr);

        if (instr_gnt_o) obs_grants.push_back(0);
        if (data_gnt_o)  obs_grants.push_back(1);

        n_pop      = pop;
        n_push_src = (sel >= 0 && mem_gnt_i) ? sel : -1;
        n_lock     = (sel >= 0 && !mem_gnt_i) ? sel : -1;
        n_perr_set = mem_rvalid_i && (m_q.size() == 0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (n_pop) void'(m_q.pop_front());
        if (n_push_src >= 0) begin
            m_q.push_back(n_push_src);
            m_rr = 1 - n_push_src;
        end
        m_locked = n_lock;
        if (n_perr_set) m_perr = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst.mem_req",   mem_req_o,      1'b0);
        chk("rst.mem_addr",  mem_addr_o,     32'h0);
        chk("rst.mem_be",    mem_be_o,       4'h0);
        chk("rst.gnt",       {instr_gnt_o, data_gnt_o}, 2'b00);
        chk("rst.rvalid",    {instr_rvalid_o, data_rvalid_o}, 2'b00);
        chk("rst.outstand",  outstanding_o,  0);
        chk("rst.proto_err", protocol_err_o, 1'b0);
        m_q.delete();
        m_locked = -1;
        m_perr   = 1'b0;
        m_rr     = 0;
        obs_grants.delete();
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        idle_inputs();
        for (int k = 0; k < MAXO + 2 && m_q.size() > 0; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
            check_cycle("drain");
            tick();
        end
        idle_inputs();
        check_cycle("drained");
        chk("drain.empty", outstanding_o, 0);
        tick();
    endtask

    bit last_ig, last_dg;

    initial begin
        idle_inputs();
        #2;

        // Data-only read, response two cycles later.
        do_reset();
        data_req_i = 1'b1; data_addr_i = 32'h100; data_be_i = 4'hF; mem_gnt_i = 1'b1;
        check_cycle("t1.req");
        chk("t1.d_gnt", data_gnt_o, 1'b1);
        chk("t1.addr",  mem_addr_o, 32'h100);
        tick();
        idle_inputs();
        check_cycle("t1.wait");
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        check_cycle("t1.rsp");
        chk("t1.d_rvalid", data_rvalid_o,  1'b1);
        chk("t1.d_rdata",  data_rdata_o,   32'hDEADBEEF);
        chk("t1.i_rvalid", instr_rvalid_o, 1'b0);
        tick();
        idle_inputs();
        check_cycle("t1.done");
        tick();

        // Simultaneous requests, then in-order responses.
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        data_req_i  = 1'b1; data_addr_i  = 32'h2000; data_we_i = 1'b1;
        data_wdata_i = 32'hCAFE0001; data_be_i = 4'h6; mem_gnt_i = 1'b1;
        check_cycle("t2.first");
        chk("t2.first_d", data_gnt_o,  FIRST == 1);
        chk("t2.first_i", instr_gnt_o, FIRST == 0);
        tick();
        if (FIRST == 1) data_req_i = 1'b0;
        else            instr_req_i = 1'b0;
        check_cycle("t2.second");
        chk("t2.second_d", data_gnt_o,  FIRST == 0);
        chk("t2.second_i", instr_gnt_o, FIRST == 1);
        tick();
        idle_inputs();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11111111;
        check_cycle("t2.rsp1");
        chk("t2.rsp1_d", data_rvalid_o, FIRST == 1);
        tick();
        mem_rdata_i = 32'h22222222; mem_err_i = 1'b1;
        check_cycle("t2.rsp2");
        chk("t2.rsp2_i", instr_rvalid_o, FIRST == 1);
        tick();
        idle_inputs();
        check_cycle("t2.done");
        tick();

        // Back-pressure: instr address held while data waits.
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h200; mem_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                data_req_i = 1'b1; data_addr_i = 32'h300; data_we_i = 1'b1;
                data_wdata_i = 32'h12345678; data_be_i = 4'h3;
            end
            check_cycle("t3.stall");
            chk("t3.addr_hold", mem_addr_o, 32'h200);
            chk("t3.no_dgnt",   data_gnt_o, 1'b0);
            tick();
        end
        mem_gnt_i = 1'b1;
        check_cycle("t3.igrant");
        chk("t3.i_gnt", instr_gnt_o, 1'b1);
        chk("t3.iaddr", mem_addr_o,  32'h200);
        tick();
        instr_req_i = 1'b0;
        check_cycle("t3.dgrant");
        chk("t3.d_gnt", data_gnt_o, 1'b1);
        chk("t3.daddr", mem_addr_o, 32'h300);
        tick();
        drain();

        // Full FIFO, then push+pop in the same cycle.
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h400; mem_gnt_i = 1'b1;
        check_cycle("t4.g1"); tick();
        check_cycle("t4.g2"); tick();
        check_cycle("t4.full");
        chk("t4.no_req", mem_req_o,     1'b0);
        chk("t4.no_gnt", instr_gnt_o,   1'b0);
        chk("t4.occ",    outstanding_o, 2);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000A5A5;
        check_cycle("t4.pushpop");
        chk("t4.req",      mem_req_o,      1'b1);
        chk("t4.gnt",      instr_gnt_o,    1'b1);
        chk("t4.i_rvalid", instr_rvalid_o, 1'b1);
        tick();
        instr_req_i = 1'b0; mem_rvalid_i = 1'b0;
        check_cycle("t4.after");
        chk("t4.occ_kept", outstanding_o, 2);
        tick();
        drain();

        // Stray response with nothing outstanding.
        do_reset();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555AAAA;
        check_cycle("t5.stray");
        chk("t5.i_rvalid", instr_rvalid_o, 1'b0);
        chk("t5.d_rvalid", data_rvalid_o,  1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        repeat (3) begin
            check_cycle("t5.hold");
            chk("t5.sticky", protocol_err_o, 1'b1);
            tick();
        end
        do_reset();
        chk("t5.cleared", protocol_err_o, 1'b0);

        // Both requesting continuously with a grant every cycle.
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h1000;
        data_req_i  = 1'b1; data_addr_i  = 32'h3000; data_be_i = 4'hF;
        mem_gnt_i   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mem_rvalid_i = (c > 0);
            check_cycle("t6.cont");
            tick();
        end
        chk("t6.count", obs_grants.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t6.grant%0d", k),
                (k < obs_grants.size()) ? obs_grants[k] : -1,
                RR ? (k % 2) : (DPRIO ? 1 : 0));
        end

        // Randomised traffic against the model; requesters hold until granted.
        do_reset();
        last_ig = 1'b0;
        last_dg = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!instr_req_i || last_ig) begin
                instr_req_i  = 1'($urandom_range(0, 1));
                instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_req_i || last_dg) begin
                data_req_i   = 1'($urandom_range(0, 1));
                data_addr_i  = $urandom & 32'hFFFF_FFFC;
                data_we_i    = 1'($urandom_range(0, 1));
                data_be_i    = 4'($urandom_range(1, 15));
                data_wdata_i = $urandom;
            end
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom;
            mem_err_i    = 1'($urandom_range(0, 1));
            check_cycle("rand");
            last_ig = exp_igrant;
            last_dg = exp_dgrant;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
